md_sequencer: RTL and testbench

- Control-side sequencer for the iterative multiply/divide unit and the HIGH/LOW register pair in the multicycle CPU.
- Accepts a one-cycle MULT/DIV request from the main control unit and issues the multiply/divide set pulse.
- Times the operation with a cycle counter and commits the result through the HIGH/LOW write enables.
- Holds the control unit stalled via busy; detects divide-by-zero before launch and supports abort on exception flush.

---
 rtl/md_sequencer.sv | 128 ++++++++++++
 tb/tb_md_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/md_sequencer.sv
// Control sequencer for the iterative multiply/divide unit and the HIGH/LOW register pair.
// Optional busy-cycle performance counter is built when MD_PERF_COUNT_EN is defined.
//
// state  | meaning
// IDLE   | waiting for a MULT/DIV request
// LAUNCH | md_set pulse to the multiply/divide unit
// RUN    | operation in progress, counter counting down to 1
// WRITE  | HIGH/LOW write enables asserted
// DONE   | completion pulse
// ERR    | divide-by-zero exception pulse
module md_sequencer #(
  parameter int MULT_CYCLES = 32,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] divisor,
  input  logic        abort,
  output logic        md_set,
  output logic        hi_we,
  output logic        lo_we,
  output logic        busy,
  output logic        done,
  output logic        div0_err,
  output logic [31:0] perf_busy_cycles
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             op_q, op_q_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      op_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      op_q  <= op_q_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    op_q_nxt  = op_q;
    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          // Divide-by-zero is caught here so the unit is never launched.
          if (op && (divisor == 32'd0)) begin
            state_nxt = S_ERR;
          end else begin
            op_q_nxt  = op;
            cnt_nxt   = op ? DIV_LOAD : MULT_LOAD;
            state_nxt = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: state_nxt = S_RUN;
      S_RUN: begin
        if (cnt == CNT_ONE) begin
          state_nxt = S_WRITE;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      S_WRITE:  state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      S_ERR:    state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    if (abort && (state != S_IDLE)) begin
      state_nxt = S_IDLE;
    end
  end

  // abort is the only input that reaches the outputs combinationally: a flush
  // arriving in WRITE must stop the HIGH/LOW update in that same cycle.
  assign md_set   = (state == S_LAUNCH);
  assign hi_we    = (state == S_WRITE) && !abort;
  assign lo_we    = (state == S_WRITE) && !abort;
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);
  assign div0_err = (state == S_ERR);

  // The count loaded for the latched operation bounds the value seen in RUN.
  always @(posedge clk) begin
    if (!rst && (state == S_RUN)) begin
      assert (cnt != '0 && cnt <= (op_q ? DIV_LOAD : MULT_LOAD))
        else $error("md_sequencer: counter out of range in RUN");
    end
  end

`ifdef MD_PERF_COUNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= 32'd0;
    end else if (busy && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_busy_cycles = perf_q;
`else
  assign perf_busy_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer: default-parameter instance plus a
// MULT_CYCLES=1 / DIV_CYCLES=3 instance sharing the same inputs.
module tb_md_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] divisor = 32'd0;
  logic        abort = 1'b0;

  logic        md_set, hi_we, lo_we, busy, done, div0_err;
  logic [31:0] perf_busy_cycles;
  logic        p_md_set, p_hi_we, p_lo_we, p_busy, p_done, p_div0_err;
  logic [31:0] p_perf_busy_cycles;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  md_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .divisor(divisor), .abort(abort),
    .md_set(md_set), .hi_we(hi_we), .lo_we(lo_we), .busy(busy), .done(done),
    .div0_err(div0_err), .perf_busy_cycles(perf_busy_cycles)
  );

  md_sequencer #(.MULT_CYCLES(1), .DIV_CYCLES(3), .CNT_W(2)) dut_p (
    .clk(clk), .rst(rst), .start(start), .op(op), .divisor(divisor), .abort(abort),
    .md_set(p_md_set), .hi_we(p_hi_we), .lo_we(p_lo_we), .busy(p_busy), .done(p_done),
    .div0_err(p_div0_err), .perf_busy_cycles(p_perf_busy_cycles)
  );

  // Event cycles are counted from the start cycle (0); 0 means "never".
  typedef struct {
    string       name;
    bit          alt;
    bit          op;
    logic [31:0] dvs;
    int          abort_at;
    int          set_cyc;
    int          we_cyc;
    int          done_cyc;
    int          err_cyc;
    int          busy_cnt;
  } vec_t;

`ifdef MD_PERF_COUNT_EN
  localparam int PERF_AFTER_FIRST = 35;
`else
  localparam int PERF_AFTER_FIRST = 0;
`endif

  task automatic check(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int set_n = 0, we_n = 0, done_n = 0, err_n = 0, busy_n = 0, split = 0;
    int set_c = 0, we_c = 0, done_c = 0, err_c = 0;
    logic s, h, l, b, d, e;
    start   = 1'b1;
    op      = v.op;
    divisor = v.dvs;
    abort   = (v.abort_at == 0);
    tick();
    start   = 1'b0;
    op      = ~v.op;
    divisor = 32'd0;
    abort   = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      abort = (c == v.abort_at);
      #1;
      s = v.alt ? p_md_set   : md_set;
      h = v.alt ? p_hi_we    : hi_we;
      l = v.alt ? p_lo_we    : lo_we;
      b = v.alt ? p_busy     : busy;
      d = v.alt ? p_done     : done;
      e = v.alt ? p_div0_err : div0_err;
      if (s) begin set_n++; if (set_c == 0) set_c = c; end
      if (h) begin we_n++;  if (we_c == 0)  we_c = c;  end
      if (d) begin done_n++; if (done_c == 0) done_c = c; end
      if (e) begin err_n++; if (err_c == 0) err_c = c; end
      if (b) busy_n++;
      if (h != l) split++;
      tick();
    end
    abort = 1'b0;
    check({v.name, " md_set count"}, set_n, (v.set_cyc != 0) ? 1 : 0);
    check({v.name, " md_set cycle"}, set_c, v.set_cyc);
    check({v.name, " hi_we count"}, we_n, (v.we_cyc != 0) ? 1 : 0);
    check({v.name, " hi_we cycle"}, we_c, v.we_cyc);
    check({v.name, " done count"}, done_n, (v.done_cyc != 0) ? 1 : 0);
    check({v.name, " done cycle"}, done_c, v.done_cyc);
    check({v.name, " div0_err count"}, err_n, (v.err_cyc != 0) ? 1 : 0);
    check({v.name, " div0_err cycle"}, err_c, v.err_cyc);
    check({v.name, " busy cycles"}, busy_n, v.busy_cnt);
    check({v.name, " hi_we/lo_we split"}, split, 0);
    check({v.name, " idle at end"}, v.alt ? p_busy : busy, 0);
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back('{"mult",          0, 0, 32'd5, -1, 1, 34, 35, 0, 35});
    vecs.push_back('{"mult_div0",     0, 0, 32'd0, -1, 1, 34, 35, 0, 35});
    vecs.push_back('{"div7",          0, 1, 32'd7, -1, 1, 34, 35, 0, 35});
    vecs.push_back('{"div_by_zero",   0, 1, 32'd0, -1, 0,  0,  0, 1,  1});
    vecs.push_back('{"abort_write",   0, 0, 32'd5, 34, 1,  0,  0, 0, 34});
    vecs.push_back('{"after_abort",   0, 1, 32'd3, -1, 1, 34, 35, 0, 35});
    vecs.push_back('{"abort_run",     0, 1, 32'd9, 10, 1,  0,  0, 0, 10});
    vecs.push_back('{"abort_launch",  0, 0, 32'd1,  1, 1,  0,  0, 0,  1});
    vecs.push_back('{"abort_done",    0, 0, 32'd1, 35, 1, 34, 35, 0, 35});
    vecs.push_back('{"abort_w_start", 0, 0, 32'd1,  0, 0,  0,  0, 0,  0});
    vecs.push_back('{"p_mult",        1, 0, 32'd4, -1, 1,  3,  4, 0,  4});
    vecs.push_back('{"p_div",         1, 1, 32'd9, -1, 1,  5,  6, 0,  6});
    vecs.push_back('{"p_div_by_zero", 1, 1, 32'd0, -1, 0,  0,  0, 1,  1});

    // Reset held with start high: everything idle and quiet.
    rst   = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("reset outputs", {md_set, hi_we, lo_we, busy, done, div0_err}, 0);
      check("reset perf", perf_busy_cycles, 0);
    end
    rst   = 1'b0;
    start = 1'b0;
    tick();

    foreach (vecs[i]) begin
      run_vec(vecs[i]);
      if (i == 0) check("perf after first mult", perf_busy_cycles, PERF_AFTER_FIRST);
    end

    // start held high for 40 cycles: second launch only once IDLE again.
    begin
      int set_n = 0, set1 = 0, set2 = 0, done_n = 0, done1 = 0, guard = 0;
      start   = 1'b1;
      op      = 1'b0;
      divisor = 32'd3;
      tick();
      for (int c = 1; c <= 75; c++) begin
        start = (c < 40);
        #1;
        if (md_set) begin
          set_n++;
          if (set_n == 1) set1 = c;
          if (set_n == 2) set2 = c;
        end
        if (done) begin
          done_n++;
          if (done_n == 1) done1 = c;
        end
        tick();
      end
      start = 1'b0;
      while (busy && guard < 100) begin
        guard++;
        tick();
      end
      check("b2b md_set count", set_n, 2);
      check("b2b first md_set", set1, 1);
      check("b2b second md_set", set2, 37);
      check("b2b first done", done1, 35);
      check("b2b done count", done_n, 2);
      check("b2b returns idle", busy, 0);
    end

    // Reset in the middle of a MULT: the operation is discarded.
    begin
      int we_n = 0, done_n = 0;
      start   = 1'b1;
      op      = 1'b0;
      divisor = 32'd2;
      tick();
      start = 1'b0;
      for (int c = 1; c < 20; c++) tick();
      check("mid busy before reset", busy, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid reset outputs", {md_set, hi_we, lo_we, busy, done, div0_err}, 0);
      check("mid reset perf", perf_busy_cycles, 0);
      for (int c = 0; c < 25; c++) begin
        if (hi_we || lo_we) we_n++;
        if (done) done_n++;
        tick();
      end
      check("mid reset no write", we_n, 0);
      check("mid reset no done", done_n, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
